// File: rtl/issue_queue_if.sv
// Decode-to-issue bus for issue_queue.
//   Decode side : in_valid0/1, in_uop0/1, in_rd/rj/rk0/1, in_imm0/1, in_pc0/1,
//                 in_pc_next0/1, in_exp0/1 (slot 0 is the older uop), in_ready back.
//   Issue side  : registered eu0_* (any uop type) and eu1_* (ALU only) lane fields.
// Handshake: decode presents uops whenever it likes; a slot is taken at a clock edge
// only when in_ready is 1 and no flush is pending. When in_ready is 0 the uops
// are dropped and decode must hold them for a later cycle. There is no back-pressure
// on the issue side other than the separate stall input of the queue.
// modport master = decode/execute environment, modport slave = the queue.

`ifndef ISSUE_QUEUE_DEFS
`define ISSUE_QUEUE_DEFS
`define WIDTH_UOP 8
`define UOP_TYPE  7:5
`define ITYPE_ALU 3'd1
`define ITYPE_BR  3'd2
`endif

interface issue_queue_if;
    logic                  in_valid0;
    logic                  in_valid1;
    logic [`WIDTH_UOP-1:0] in_uop0;
    logic [`WIDTH_UOP-1:0] in_uop1;
    logic [4:0]            in_rd0, in_rj0, in_rk0;
    logic [4:0]            in_rd1, in_rj1, in_rk1;
    logic [31:0]           in_imm0, in_imm1;
    logic [31:0]           in_pc0, in_pc1;
    logic [31:0]           in_pc_next0, in_pc_next1;
    logic [6:0]            in_exp0, in_exp1;
    logic                  in_ready;

    logic                  eu0_en_out;
    logic [`WIDTH_UOP-1:0] eu0_uop_out;
    logic [4:0]            eu0_rd_out, eu0_rj_out, eu0_rk_out;
    logic [31:0]           eu0_imm_out, eu0_pc_out, eu0_pc_next_out;
    logic [6:0]            eu0_exp_out;

    logic                  eu1_en_out;
    logic [`WIDTH_UOP-1:0] eu1_uop_out;
    logic [4:0]            eu1_rd_out, eu1_rj_out, eu1_rk_out;

    modport master (
        output in_valid0, in_valid1, in_uop0, in_uop1,
               in_rd0, in_rj0, in_rk0, in_rd1, in_rj1, in_rk1,
               in_imm0, in_imm1, in_pc0, in_pc1, in_pc_next0, in_pc_next1,
               in_exp0, in_exp1,
        input  in_ready,
               eu0_en_out, eu0_uop_out, eu0_rd_out, eu0_rj_out, eu0_rk_out,
               eu0_imm_out, eu0_pc_out, eu0_pc_next_out, eu0_exp_out,
               eu1_en_out, eu1_uop_out, eu1_rd_out, eu1_rj_out, eu1_rk_out
    );

    modport slave (
        input  in_valid0, in_valid1, in_uop0, in_uop1,
               in_rd0, in_rj0, in_rk0, in_rd1, in_rj1, in_rk1,
               in_imm0, in_imm1, in_pc0, in_pc1, in_pc_next0, in_pc_next1,
               in_exp0, in_exp1,
        output in_ready,
               eu0_en_out, eu0_uop_out, eu0_rd_out, eu0_rj_out, eu0_rk_out,
               eu0_imm_out, eu0_pc_out, eu0_pc_next_out, eu0_exp_out,
               eu1_en_out, eu1_uop_out, eu1_rd_out, eu1_rj_out, eu1_rk_out
    );
endinterface

// File: rtl/issue_queue.sv
// issue_queue: in-order dual-issue buffer between decode and register-file read.
// Holds up to DEPTH decoded uops, accepts up to two per cycle and issues up to two
// per cycle: lane eu0 takes any uop, lane eu1 takes an ALU uop paired behind eu0.
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   stall            execute stall: outputs hold, no dequeue, enqueue continues
//   flush            branch flush: queue emptied, both lanes disabled, decode ignored
//   bus              issue_queue_if.slave (decode inputs, in_ready, eu0/eu1 outputs)
//   dbg_count_o      current occupancy
//   dbg_head_o/tail_o  read/write pointers

`ifndef ISSUE_QUEUE_DEFS
`define ISSUE_QUEUE_DEFS
`define WIDTH_UOP 8
`define UOP_TYPE  7:5
`define ITYPE_ALU 3'd1
`define ITYPE_BR  3'd2
`endif

module issue_queue #(
    parameter int DEPTH = 8,
    parameter int PTRW  = 3
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            stall,
    input  logic            flush,
    issue_queue_if.slave    bus,
    output logic [PTRW:0]   dbg_count_o,
    output logic [PTRW-1:0] dbg_head_o,
    output logic [PTRW-1:0] dbg_tail_o
);
    localparam int CW = PTRW + 1;

    typedef struct packed {
        logic [`WIDTH_UOP-1:0] uop;
        logic [4:0]            rd;
        logic [4:0]            rj;
        logic [4:0]            rk;
        logic [31:0]           imm;
        logic [31:0]           pc;
        logic [31:0]           pc_next;
        logic [6:0]            exp;
    } entry_t;

    entry_t          mem_q [DEPTH];
    logic [PTRW-1:0] head_q, tail_q;
    logic [CW-1:0]   count_q, count_d;

    entry_t          slot0, slot1, h0, h1;
    logic [PTRW-1:0] head_p1, wr1_ptr;
    logic            accept, pair_ok;
    logic [1:0]      n_enq, n_deq, n_issue;

    assign slot0 = '{bus.in_uop0, bus.in_rd0, bus.in_rj0, bus.in_rk0,
                     bus.in_imm0, bus.in_pc0, bus.in_pc_next0, bus.in_exp0};
    assign slot1 = '{bus.in_uop1, bus.in_rd1, bus.in_rj1, bus.in_rk1,
                     bus.in_imm1, bus.in_pc1, bus.in_pc_next1, bus.in_exp1};

    // Room for a full decode pair, independent of how many slots are valid.
    assign bus.in_ready = (count_q <= CW'(DEPTH - 2));
    assign accept       = bus.in_ready && !flush;

    assign head_p1 = head_q + PTRW'(1);
    assign h0      = mem_q[head_q];
    assign h1      = mem_q[head_p1];
    // A lone in_valid1 lands at tail, so slot 1 follows slot 0 only when slot 0 is used.
    assign wr1_ptr = bus.in_valid0 ? (tail_q + PTRW'(1)) : tail_q;

    always_comb begin
        pair_ok = (count_q >= CW'(2))
               && (h1.uop[`UOP_TYPE] == `ITYPE_ALU)
               && (h0.uop[`UOP_TYPE] != `ITYPE_BR)
               && (h0.exp == '0) && (h1.exp == '0)
               && ((h0.rd == '0) ||
                   ((h1.rj != h0.rd) && (h1.rk != h0.rd) && (h1.rd != h0.rd)));
        if (pair_ok)
            n_issue = 2'd2;
        else if (count_q != '0)
            n_issue = 2'd1;
        else
            n_issue = 2'd0;
        n_enq   = accept ? ({1'b0, bus.in_valid0} + {1'b0, bus.in_valid1}) : 2'd0;
        n_deq   = (flush || stall) ? 2'd0 : n_issue;
        count_d = count_q + CW'(n_enq) - CW'(n_deq);
    end

    // Entry storage carries no reset: occupancy is tracked by count/pointers only.
    always_ff @(posedge clk) begin
        if (accept) begin
            if (bus.in_valid0)
                mem_q[tail_q] <= slot0;
            if (bus.in_valid1)
                mem_q[wr1_ptr] <= slot1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head_q              <= '0;
            tail_q              <= '0;
            count_q             <= '0;
            bus.eu0_en_out      <= 1'b0;
            bus.eu0_uop_out     <= '0;
            bus.eu0_rd_out      <= '0;
            bus.eu0_rj_out      <= '0;
            bus.eu0_rk_out      <= '0;
            bus.eu0_imm_out     <= '0;
            bus.eu0_pc_out      <= '0;
            bus.eu0_pc_next_out <= '0;
            bus.eu0_exp_out     <= '0;
            bus.eu1_en_out      <= 1'b0;
            bus.eu1_uop_out     <= '0;
            bus.eu1_rd_out      <= '0;
            bus.eu1_rj_out      <= '0;
            bus.eu1_rk_out      <= '0;
        end else if (flush) begin
            head_q         <= tail_q;
            count_q        <= '0;
            bus.eu0_en_out <= 1'b0;
            bus.eu1_en_out <= 1'b0;
        end else begin
            tail_q  <= tail_q + PTRW'(n_enq);
            count_q <= count_d;
            if (!stall) begin
                head_q              <= head_q + PTRW'(n_deq);
                bus.eu0_en_out      <= (n_issue != 2'd0);
                bus.eu0_uop_out     <= h0.uop;
                bus.eu0_rd_out      <= h0.rd;
                bus.eu0_rj_out      <= h0.rj;
                bus.eu0_rk_out      <= h0.rk;
                bus.eu0_imm_out     <= h0.imm;
                bus.eu0_pc_out      <= h0.pc;
                bus.eu0_pc_next_out <= h0.pc_next;
                bus.eu0_exp_out     <= h0.exp;
                bus.eu1_en_out      <= (n_issue == 2'd2);
                bus.eu1_uop_out     <= h1.uop;
                bus.eu1_rd_out      <= h1.rd;
                bus.eu1_rj_out      <= h1.rj;
                bus.eu1_rk_out      <= h1.rk;
            end
        end
    end

    assign dbg_count_o = count_q;
    assign dbg_head_o  = head_q;
    assign dbg_tail_o  = tail_q;
endmodule

// File: tb/tb_issue_queue.sv
module tb_issue_queue;
    localparam int DEPTH = 8;
    localparam int PTRW  = 3;
    localparam int T_ALU = 1;
    localparam int T_BR  = 2;
    localparam int T_LSU = 3;
    localparam int T_MUL = 4;

    typedef struct packed {
        logic [7:0]  uop;
        logic [4:0]  rd;
        logic [4:0]  rj;
        logic [4:0]  rk;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] pc_next;
        logic [6:0]  exp;
    } ent_t;
    localparam int ENT_W = $bits(ent_t);

    typedef struct {
        bit v0; bit v1;
        int t0; int rd0; int rj0; int rk0; int x0;
        int t1; int rd1; int rj1; int rk1; int x1;
        bit st; bit fl;
        bit e_en0; bit e_en1; int e_rd0; int e_x0; int e_cnt;
    } vec_t;

    // ---------------- clock / reset / DUT ----------------
    logic            clk;
    logic            rstn;
    logic            stall;
    logic            flush;
    logic [PTRW:0]   dbg_count;
    logic [PTRW-1:0] dbg_head;
    logic [PTRW-1:0] dbg_tail;

    issue_queue_if bus();

    issue_queue #(.DEPTH(DEPTH), .PTRW(PTRW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .stall      (stall),
        .flush      (flush),
        .bus        (bus),
        .dbg_count_o(dbg_count),
        .dbg_head_o (dbg_head),
        .dbg_tail_o (dbg_tail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard / reference model ----------------
    int   checks;
    int   failures;
    logic [ENT_W-1:0] exp_q[$];
    bit   m_en0, m_en1;
    ent_t m_o0, m_o1;
    int   m_head, m_tail;
    bit   cur_v0, cur_v1, cur_st, cur_fl;
    ent_t cur_e0, cur_e1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic ent_t mk(input int t, input int rd, input int rj, input int rk, input int x);
        ent_t e;
        e.uop     = {3'(t), 5'($urandom)};
        e.rd      = 5'(rd);
        e.rj      = 5'(rj);
        e.rk      = 5'(rk);
        e.imm     = $urandom;
        e.pc      = $urandom & 32'hffff_fffc;
        e.pc_next = e.pc + 32'd4;
        e.exp     = 7'(x);
        return e;
    endfunction

    function automatic vec_t mkv(input bit v0, input bit v1,
                                 input int t0, input int rd0, input int rj0, input int rk0, input int x0,
                                 input int t1, input int rd1, input int rj1, input int rk1, input int x1,
                                 input bit st, input bit fl,
                                 input bit en0, input bit en1, input int erd, input int ex, input int cnt);
        vec_t v;
        v.v0 = v0; v.v1 = v1;
        v.t0 = t0; v.rd0 = rd0; v.rj0 = rj0; v.rk0 = rk0; v.x0 = x0;
        v.t1 = t1; v.rd1 = rd1; v.rj1 = rj1; v.rk1 = rk1; v.x1 = x1;
        v.st = st; v.fl = fl;
        v.e_en0 = en0; v.e_en1 = en1; v.e_rd0 = erd; v.e_x0 = ex; v.e_cnt = cnt;
        return v;
    endfunction

    function automatic vec_t idle(input bit fl, input bit en0, input bit en1, input int erd,
                                  input int ex, input int cnt);
        return mkv(0, 0, T_ALU, 0, 0, 0, 0, T_ALU, 0, 0, 0, 0, 0, fl, en0, en1, erd, ex, cnt);
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_en0 = 0; m_en1 = 0;
        m_o0 = '0; m_o1 = '0;
        m_head = 0; m_tail = 0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input bit v0, input ent_t e0, input bit v1, input ent_t e1,
                         input bit st, input bit fl);
        cur_v0 = v0; cur_e0 = e0; cur_v1 = v1; cur_e1 = e1; cur_st = st; cur_fl = fl;
        bus.in_valid0 = v0;           bus.in_valid1 = v1;
        bus.in_uop0 = e0.uop;         bus.in_uop1 = e1.uop;
        bus.in_rd0 = e0.rd;           bus.in_rd1 = e1.rd;
        bus.in_rj0 = e0.rj;           bus.in_rj1 = e1.rj;
        bus.in_rk0 = e0.rk;           bus.in_rk1 = e1.rk;
        bus.in_imm0 = e0.imm;         bus.in_imm1 = e1.imm;
        bus.in_pc0 = e0.pc;           bus.in_pc1 = e1.pc;
        bus.in_pc_next0 = e0.pc_next; bus.in_pc_next1 = e1.pc_next;
        bus.in_exp0 = e0.exp;         bus.in_exp1 = e1.exp;
        stall = st;
        flush = fl;
    endtask

    task automatic drive_idle(input bit st, input bit fl);
        drive(0, mk(T_ALU, 0, 0, 0, 0), 0, mk(T_ALU, 0, 0, 0, 0), st, fl);
    endtask

    task automatic compare_model();
        chk("en0", bus.eu0_en_out, m_en0);
        chk("en1", bus.eu1_en_out, m_en1);
        chk("count", dbg_count, exp_q.size());
        chk("head", dbg_head, m_head);
        chk("tail", dbg_tail, m_tail);
        chk("in_ready", bus.in_ready, (DEPTH - exp_q.size()) >= 2);
        if (m_en0) begin
            chk("eu0_uop", bus.eu0_uop_out, m_o0.uop);
            chk("eu0_rd", bus.eu0_rd_out, m_o0.rd);
            chk("eu0_rj", bus.eu0_rj_out, m_o0.rj);
            chk("eu0_rk", bus.eu0_rk_out, m_o0.rk);
            chk("eu0_imm", bus.eu0_imm_out, m_o0.imm);
            chk("eu0_pc", bus.eu0_pc_out, m_o0.pc);
            chk("eu0_pc_next", bus.eu0_pc_next_out, m_o0.pc_next);
            chk("eu0_exp", bus.eu0_exp_out, m_o0.exp);
        end
        if (m_en1) begin
            chk("eu1_uop", bus.eu1_uop_out, m_o1.uop);
            chk("eu1_rd", bus.eu1_rd_out, m_o1.rd);
            chk("eu1_rj", bus.eu1_rj_out, m_o1.rj);
            chk("eu1_rk", bus.eu1_rk_out, m_o1.rk);
        end
    endtask

    // One clock: update the reference queue from the current inputs, take the edge, compare.
    task automatic step();
        int   n, nis, nenq;
        bit   rdy;
        ent_t h0, h1;
        n = exp_q.size();
        rdy = (DEPTH - n) >= 2;
        h0 = '0; h1 = '0; nis = 0;
        if (n >= 1) h0 = ent_t'(exp_q[0]);
        if (n >= 2) h1 = ent_t'(exp_q[1]);
        if (n >= 2 && h1.uop[7:5] == 3'(T_ALU) && h0.uop[7:5] != 3'(T_BR) &&
            h0.exp == 0 && h1.exp == 0 &&
            (h0.rd == 0 || (h1.rj != h0.rd && h1.rk != h0.rd && h1.rd != h0.rd)))
            nis = 2;
        else if (n >= 1)
            nis = 1;
        if (cur_fl) begin
            exp_q.delete();
            m_en0 = 0; m_en1 = 0;
            m_head = m_tail;
        end else begin
            if (!cur_st) begin
                m_en0 = (nis >= 1);
                m_en1 = (nis == 2);
                if (nis >= 1) begin m_o0 = h0; void'(exp_q.pop_front()); end
                if (nis == 2) begin m_o1 = h1; void'(exp_q.pop_front()); end
                m_head = (m_head + nis) % DEPTH;
            end
            if (rdy) begin
                nenq = 0;
                if (cur_v0) begin exp_q.push_back(cur_e0); nenq++; end
                if (cur_v1) begin exp_q.push_back(cur_e1); nenq++; end
                m_tail = (m_tail + nenq) % DEPTH;
            end
        end
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic step_pair(input int rd_a, input int rd_b, input bit st);
        drive(1, mk(T_ALU, rd_a, 1, 2, 0), 1, mk(T_ALU, rd_b, 1, 2, 0), st, 0);
        step();
    endtask

    task automatic chk_hand(input string name, input bit en0, input bit en1, input int rd0,
                            input int cnt, input bit rdy);
        chk({name, "_en0"}, bus.eu0_en_out, en0);
        chk({name, "_en1"}, bus.eu1_en_out, en1);
        if (en0) chk({name, "_rd0"}, bus.eu0_rd_out, rd0);
        chk({name, "_count"}, dbg_count, cnt);
        chk({name, "_in_ready"}, bus.in_ready, rdy);
    endtask

    // ---------------- stimulus ----------------
    vec_t tbl[23];

    initial begin
        checks = 0;
        failures = 0;
        model_reset();
        drive_idle(0, 0);
        rstn = 1'b1;
        #1 rstn = 1'b0;
        #1;
        chk("rst_en0", bus.eu0_en_out, 0);
        chk("rst_en1", bus.eu1_en_out, 0);
        chk("rst_rd0", bus.eu0_rd_out, 0);
        chk("rst_exp0", bus.eu0_exp_out, 0);
        chk("rst_rd1", bus.eu1_rd_out, 0);
        chk("rst_count", dbg_count, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        @(negedge clk);
        rstn = 1'b1;

        // Directed vectors: {inputs} -> {en0, en1, rd0, exp0, count} after the edge.
        tbl[0]  = mkv(1, 1, T_ALU, 4, 1, 2, 0, T_ALU, 7, 5, 6, 0, 0, 0, 0, 0, 0, 0, 2);
        tbl[1]  = idle(0, 1, 1, 4, 0, 0);
        tbl[2]  = mkv(1, 1, T_ALU, 4, 1, 1, 0, T_ALU, 8, 4, 2, 0, 0, 0, 0, 0, 0, 0, 2);
        tbl[3]  = idle(0, 1, 0, 4, 0, 1);
        tbl[4]  = idle(0, 1, 0, 8, 0, 0);
        tbl[5]  = idle(0, 0, 0, 0, 0, 0);
        tbl[6]  = mkv(1, 1, T_ALU, 3, 1, 2, 8, T_ALU, 9, 1, 2, 0, 0, 0, 0, 0, 0, 0, 2);
        tbl[7]  = idle(0, 1, 0, 3, 8, 1);
        tbl[8]  = idle(0, 1, 0, 9, 0, 0);
        tbl[9]  = idle(0, 0, 0, 0, 0, 0);
        tbl[10] = mkv(1, 1, T_BR, 0, 1, 2, 0, T_ALU, 5, 1, 2, 0, 0, 0, 0, 0, 0, 0, 2);
        tbl[11] = idle(0, 1, 0, 0, 0, 1);
        tbl[12] = idle(1, 0, 0, 0, 0, 0);
        tbl[13] = idle(0, 0, 0, 0, 0, 0);
        tbl[14] = mkv(0, 1, T_ALU, 0, 0, 0, 0, T_ALU, 11, 1, 2, 0, 0, 0, 0, 0, 0, 0, 1);
        tbl[15] = idle(0, 1, 0, 11, 0, 0);
        tbl[16] = mkv(1, 1, T_ALU, 0, 0, 0, 0, T_ALU, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2);
        tbl[17] = idle(0, 1, 1, 0, 0, 0);
        tbl[18] = mkv(1, 1, T_ALU, 1, 2, 3, 0, T_LSU, 2, 3, 4, 0, 0, 0, 0, 0, 0, 0, 2);
        tbl[19] = idle(0, 1, 0, 1, 0, 1);
        tbl[20] = idle(0, 1, 0, 2, 0, 0);
        tbl[21] = mkv(1, 1, T_ALU, 5, 1, 2, 0, T_ALU, 6, 1, 2, 0, 0, 1, 0, 0, 0, 0, 0);
        tbl[22] = idle(0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 23; i++) begin
            drive(tbl[i].v0, mk(tbl[i].t0, tbl[i].rd0, tbl[i].rj0, tbl[i].rk0, tbl[i].x0),
                  tbl[i].v1, mk(tbl[i].t1, tbl[i].rd1, tbl[i].rj1, tbl[i].rk1, tbl[i].x1),
                  tbl[i].st, tbl[i].fl);
            step();
            chk($sformatf("vec%0d_en0", i), bus.eu0_en_out, tbl[i].e_en0);
            chk($sformatf("vec%0d_en1", i), bus.eu1_en_out, tbl[i].e_en1);
            chk($sformatf("vec%0d_count", i), dbg_count, tbl[i].e_cnt);
            if (tbl[i].e_en0) begin
                chk($sformatf("vec%0d_rd0", i), bus.eu0_rd_out, tbl[i].e_rd0);
                chk($sformatf("vec%0d_exp0", i), bus.eu0_exp_out, tbl[i].e_x0);
            end
        end

        // Fill to full under stall, one dropped pair, then drain two per cycle (pointer wrap).
        step_pair(10, 11, 1); chk_hand("fill1", 0, 0, 0, 2, 1);
        step_pair(12, 13, 1); chk_hand("fill2", 0, 0, 0, 4, 1);
        step_pair(14, 15, 1); chk_hand("fill3", 0, 0, 0, 6, 1);
        step_pair(16, 17, 1); chk_hand("fill4", 0, 0, 0, 8, 0);
        step_pair(30, 31, 1); chk_hand("drop", 0, 0, 0, 8, 0);
        drive_idle(0, 0); step(); chk_hand("drain1", 1, 1, 10, 6, 1);
        drive_idle(0, 0); step(); chk_hand("drain2", 1, 1, 12, 4, 1);
        drive_idle(0, 0); step(); chk_hand("drain3", 1, 1, 14, 2, 1);
        drive_idle(0, 0); step(); chk_hand("drain4", 1, 1, 16, 0, 1);
        drive_idle(0, 0); step(); chk_hand("drain5", 0, 0, 0, 0, 1);

        // Asynchronous reset with count = 5 and both lanes enabled.
        step_pair(20, 21, 0);
        step_pair(22, 23, 0);
        step_pair(24, 25, 1);
        drive(1, mk(T_ALU, 26, 1, 2, 0), 0, mk(T_ALU, 0, 0, 0, 0), 1, 0);
        step();
        chk_hand("pre_rst", 1, 1, 20, 5, 1);
        drive_idle(0, 0);
        #2 rstn = 1'b0;
        #1;
        chk("midrst_en0", bus.eu0_en_out, 0);
        chk("midrst_en1", bus.eu1_en_out, 0);
        chk("midrst_count", dbg_count, 0);
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("postrst_in_ready", bus.in_ready, 1);

        // Random traffic against the reference queue.
        for (int i = 0; i < 600; i++) begin
            ent_t e[2];
            for (int s = 0; s < 2; s++) begin
                int r, t;
                r = $urandom_range(0, 9);
                t = (r == 6) ? T_BR : (r == 7) ? T_LSU : (r == 8) ? T_MUL : T_ALU;
                e[s] = mk(t, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                          ($urandom_range(0, 15) == 0) ? $urandom_range(1, 127) : 0);
            end
            drive($urandom_range(0, 3) != 0, e[0], $urandom_range(0, 3) != 0, e[1],
                  $urandom_range(0, 4) == 0, $urandom_range(0, 19) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
